// File: rtl/mac_feed_pkg.sv
// mac_feed_pkg: shared widths and sequencer states for the
// MAC operand feeder.
package mac_feed_pkg;

  localparam int DATA_W = 8;
  localparam int ACC_W  = 24;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    STREAM,
    DRAIN,
    DONE
  } feed_state_t;

endpackage

// File: rtl/mac_operand_feeder_if.sv
// mac_operand_feeder_if: operand writes, control, MAC link
// and result bundle between the feeder and its environment.
interface mac_operand_feeder_if;
  import mac_feed_pkg::*;

  logic              a_wr_en;
  logic [DATA_W-1:0] a_data;
  logic              a_full;
  logic              b_wr_en;
  logic [DATA_W-1:0] b_data;
  logic              b_full;
  logic              start;
  logic              busy;
  logic              mac_clr;
  logic              mac_en;
  logic [DATA_W-1:0] mac_a;
  logic [DATA_W-1:0] mac_b;
  logic [ACC_W-1:0]  mac_cout;
  logic [ACC_W-1:0]  result;
  logic              result_valid;

  modport master (
    output a_wr_en, a_data, b_wr_en, b_data,
    output start, mac_cout,
    input  a_full, b_full, busy,
    input  mac_clr, mac_en, mac_a, mac_b,
    input  result, result_valid
  );

  modport slave (
    input  a_wr_en, a_data, b_wr_en, b_data,
    input  start, mac_cout,
    output a_full, b_full, busy,
    output mac_clr, mac_en, mac_a, mac_b,
    output result, result_valid
  );

endinterface

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with extra-MSB pointers;
// full/empty decoded from current pointer state.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             wr_ok;
  logic             rd_ok;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign wr_ok = wr_en && !full;
  assign rd_ok = rd_en && !empty;
  assign rd_data = mem[rd_ptr[AW-1:0]];

  // Pointer advance; a blocked write or read leaves its pointer alone
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/mac_operand_feeder.sv
// mac_operand_feeder: A/B operand FIFOs plus a dot-product
// sequencer driving the MAC and capturing its accumulator.
module mac_operand_feeder
  import mac_feed_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter int VEC_LEN   = 16,
  parameter int DRAIN_CYC = 3
) (
  input logic                 clk,
  input logic                 rst_n,
  mac_operand_feeder_if.slave feed
);
  localparam int CNT_W = $clog2(VEC_LEN + 1);
  localparam int DRN_W = $clog2(DRAIN_CYC + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(VEC_LEN);
  localparam logic [DRN_W-1:0] DRN_LAST = DRN_W'(DRAIN_CYC - 1);

  feed_state_t       state_q;
  feed_state_t       state_d;
  logic [CNT_W-1:0]  count_q;
  logic [DRN_W-1:0]  drain_q;
  logic              a_full;
  logic              b_full;
  logic              a_empty;
  logic              b_empty;
  logic [DATA_W-1:0] a_head;
  logic [DATA_W-1:0] b_head;
  logic              pop;
  logic              busy_q;
  logic              clr_q;
  logic              en_q;
  logic              rv_q;
  logic [DATA_W-1:0] ma_q;
  logic [DATA_W-1:0] mb_q;
  logic [ACC_W-1:0]  res_q;

  sync_fifo #(.WIDTH(DATA_W), .DEPTH(DEPTH)) u_fifo_a (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (feed.a_wr_en),
    .wr_data (feed.a_data),
    .rd_en   (pop),
    .rd_data (a_head),
    .full    (a_full),
    .empty   (a_empty)
  );

  sync_fifo #(.WIDTH(DATA_W), .DEPTH(DEPTH)) u_fifo_b (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (feed.b_wr_en),
    .wr_data (feed.b_data),
    .rd_en   (pop),
    .rd_data (b_head),
    .full    (b_full),
    .empty   (b_empty)
  );

  // Pairs leave only together, and never past the vector length
  assign pop = (state_q == STREAM) && (count_q != LAST) &&
               !a_empty && !b_empty;

  // Sequencer state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state decode
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (feed.start) state_d = CLEAR;
      CLEAR:   state_d = STREAM;
      STREAM:  if (count_q == LAST) state_d = DRAIN;
      DRAIN:   if (drain_q == DRN_LAST) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Pair counter: zeroed in CLEAR, one step per issued pair
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  count_q <= '0;
    else if (state_q == CLEAR)   count_q <= '0;
    else if (pop)                count_q <= count_q + 1'b1;
  end

  // Drain counter: runs only while waiting for the MAC pipeline
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  drain_q <= '0;
    else if (state_q == DRAIN)   drain_q <= drain_q + 1'b1;
    else                         drain_q <= '0;
  end

  // Registered MAC drive, status and result capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      clr_q  <= 1'b0;
      en_q   <= 1'b0;
      rv_q   <= 1'b0;
      ma_q   <= '0;
      mb_q   <= '0;
      res_q  <= '0;
    end else begin
      busy_q <= (state_d != IDLE);
      clr_q  <= (state_d == CLEAR);
      en_q   <= pop;
      rv_q   <= (state_q == DONE);
      if (pop) begin
        ma_q <= a_head;
        mb_q <= b_head;
      end
      if (state_q == DONE) res_q <= feed.mac_cout;
    end
  end

  assign feed.a_full       = a_full;
  assign feed.b_full       = b_full;
  assign feed.busy         = busy_q;
  assign feed.mac_clr      = clr_q;
  assign feed.mac_en       = en_q;
  assign feed.mac_a        = ma_q;
  assign feed.mac_b        = mb_q;
  assign feed.result       = res_q;
  assign feed.result_valid = rv_q;

endmodule

// File: tb/tb_mac_operand_feeder.sv
// tb_mac_operand_feeder: random operand streams, a pipelined MAC
// stand-in, and a pair/result scoreboard checked by a monitor.
module tb_mac_operand_feeder;
  import mac_feed_pkg::*;

  localparam int DEPTH = 8;
  localparam int VL    = 4;
  localparam int DC    = 3;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
  } pair_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mac_operand_feeder_if feed();

  mac_operand_feeder #(
    .DEPTH(DEPTH), .VEC_LEN(VL), .DRAIN_CYC(DC)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .feed  (feed)
  );

  // MAC stand-in: product stage then accumulate stage
  logic [ACC_W-1:0] acc, prod;
  logic pv, pc;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0; prod <= '0; pv <= 1'b0; pc <= 1'b0;
    end else begin
      prod <= ACC_W'(feed.mac_a) * ACC_W'(feed.mac_b);
      pv   <= feed.mac_en;
      pc   <= feed.mac_clr;
      if (pc)      acc <= '0;
      else if (pv) acc <= acc + prod;
    end
  end
  assign feed.mac_cout = acc;

  // Reference model: operand queues paired in order, grouped by VL
  logic [7:0]       ma[$];
  logic [7:0]       mb[$];
  pair_t            exp_pairs[$];
  logic [ACC_W-1:0] exp_res[$];
  int               grp_n = 0;
  logic [ACC_W-1:0] grp_acc = '0;

  int checks = 0;
  int failures = 0;
  int results_seen = 0;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s: event missing", name);
  endtask

  function automatic void form_pairs();
    while (ma.size() > 0 && mb.size() > 0) begin
      pair_t p;
      p.a = ma.pop_front();
      p.b = mb.pop_front();
      exp_pairs.push_back(p);
      grp_acc += ACC_W'(p.a) * ACC_W'(p.b);
      grp_n++;
      if (grp_n == VL) begin
        exp_res.push_back(grp_acc);
        grp_n = 0;
        grp_acc = '0;
      end
    end
  endfunction

  function automatic void flush_model();
    ma.delete();
    mb.delete();
    exp_pairs.delete();
    exp_res.delete();
    grp_n = 0;
    grp_acc = '0;
  endfunction

  function automatic logic [63:0] outs();
    return 64'({feed.busy, feed.mac_clr, feed.mac_en,
                feed.result_valid, feed.a_full, feed.b_full,
                feed.mac_a, feed.mac_b, feed.result});
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input bit wa, input logic [7:0] va,
                    input bit wb, input logic [7:0] vb);
    feed.a_wr_en = wa;
    feed.a_data  = va;
    feed.b_wr_en = wb;
    feed.b_data  = vb;
    tick();
    feed.a_wr_en = 1'b0;
    feed.b_wr_en = 1'b0;
    if (wa) ma.push_back(va);
    if (wb) mb.push_back(vb);
    form_pairs();
  endtask

  task automatic pulse_start();
    feed.start = 1'b1;
    tick();
    feed.start = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int n = 0;
    while (results_seen < target && n < 200) begin
      tick();
      n++;
    end
    chk("done_count", 64'(results_seen), 64'(target));
  endtask

  function automatic logic [7:0] rnd();
    return 8'($urandom);
  endfunction

  // Monitor: pops expected pairs/results as the DUT presents them
  int    en_run = 0;
  int    clr_run = 0;
  bit    clr_prev = 0;
  bit    rv_prev = 0;
  pair_t mon_p;
  always @(negedge clk) begin
    if (!rst_n) begin
      en_run = 0;
      clr_run = 0;
      clr_prev = 0;
      rv_prev = 0;
    end else begin
      if (feed.mac_clr) begin
        chk("clr_one_cycle", 64'(clr_prev), 64'(0));
        chk("clr_vs_en", 64'(feed.mac_en), 64'(0));
        clr_run++;
        en_run = 0;
      end
      if (feed.mac_en) begin
        if (exp_pairs.size() == 0) begin
          fail_now("unexpected_pair");
        end else begin
          mon_p = exp_pairs.pop_front();
          chk("mac_a", 64'(feed.mac_a), 64'(mon_p.a));
          chk("mac_b", 64'(feed.mac_b), 64'(mon_p.b));
        end
        en_run++;
      end
      if (feed.result_valid) begin
        chk("rv_one_cycle", 64'(rv_prev), 64'(0));
        chk("run_pairs", 64'(en_run), 64'(VL));
        chk("run_clr", 64'(clr_run), 64'(1));
        if (exp_res.size() == 0) fail_now("unexpected_result");
        else chk("result", 64'(feed.result), 64'(exp_res.pop_front()));
        results_seen++;
        en_run = 0;
        clr_run = 0;
      end
      clr_prev = feed.mac_clr;
      rv_prev = feed.result_valid;
    end
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog: simulation did not complete");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    int n;
    bit saw;
    feed.a_wr_en = 1'b0;
    feed.a_data  = '0;
    feed.b_wr_en = 1'b0;
    feed.b_data  = '0;
    feed.start   = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", outs(), 64'(0));
    rst_n = 1'b1;
    tick();
    tick();

    // Reset mid-STREAM with B full
    wr(1'b1, rnd(), 1'b1, rnd());
    for (int i = 0; i < 7; i++) wr(1'b0, 8'h0, 1'b1, rnd());
    chk("b_full_loaded", 64'(feed.b_full), 64'(1));
    pulse_start();
    repeat (4) tick();
    wr(1'b0, 8'h0, 1'b1, rnd());
    chk("b_full_stream", 64'(feed.b_full), 64'(1));
    chk("busy_stream", 64'(feed.busy), 64'(1));
    #2;
    rst_n = 1'b0;
    #1;
    chk("reset_async", outs(), 64'(0));
    flush_model();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();

    // Start with empty FIFOs stalls in STREAM
    pulse_start();
    saw = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      saw |= feed.mac_en;
    end
    chk("stall_no_en", 64'(saw), 64'(0));
    chk("stall_busy", 64'(feed.busy), 64'(1));
    for (int i = 0; i < VL; i++) wr(1'b1, rnd(), 1'b1, rnd());
    wait_done(1);

    // Known dot product and latency
    for (int i = 0; i < VL; i++)
      wr(1'b1, 8'(i + 1), 1'b1, 8'(i + 5));
    pulse_start();
    n = 1;
    while (!feed.result_valid && n < 100) begin
      tick();
      n++;
    end
    n--;
    chk("latency", 64'(n), 64'(VL + DC + 3));
    chk("result_70", 64'(feed.result), 64'(70));
    wait_done(2);

    // Full FIFO A: 9th write dropped
    for (int i = 0; i < DEPTH; i++) wr(1'b0, 8'h0, 1'b1, rnd());
    for (int i = 1; i <= DEPTH; i++) begin
      wr(1'b1, 8'(i), 1'b0, 8'h0);
      if (i == DEPTH - 1)
        chk("a_full_7", 64'(feed.a_full), 64'(0));
    end
    chk("a_full_8", 64'(feed.a_full), 64'(1));
    feed.a_wr_en = 1'b1;
    feed.a_data  = 8'd9;
    tick();
    feed.a_wr_en = 1'b0;
    chk("a_full_9", 64'(feed.a_full), 64'(1));
    pulse_start();
    n = 0;
    while (!feed.mac_en && n < 20) begin
      tick();
      n++;
    end
    chk("a_full_pop", 64'(feed.a_full), 64'(0));
    wait_done(3);
    pulse_start();
    wait_done(4);

    // B trickles in every third cycle
    for (int i = 0; i < VL; i++) wr(1'b1, rnd(), 1'b0, 8'h0);
    pulse_start();
    for (int i = 0; i < VL; i++) begin
      wr(1'b0, 8'h0, 1'b1, rnd());
      tick();
      tick();
    end
    wait_done(5);

    // Back-to-back runs with wrapping pointers
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < VL; i++) wr(1'b1, rnd(), 1'b1, rnd());
      pulse_start();
      wait_done(6 + r);
    end

    // start during STREAM and DRAIN is ignored; extras stay queued
    for (int i = 0; i < VL + 2; i++) wr(1'b1, rnd(), 1'b1, rnd());
    pulse_start();
    tick();
    tick();
    pulse_start();
    repeat (3) tick();
    pulse_start();
    wait_done(9);
    repeat (3) tick();
    chk("no_restart", 64'(feed.busy), 64'(0));
    for (int i = 0; i < VL - 2; i++) wr(1'b1, rnd(), 1'b1, rnd());
    pulse_start();
    wait_done(10);

    repeat (3) tick();
    chk("pairs_left", 64'(exp_pairs.size()), 64'(0));
    chk("results_left", 64'(exp_res.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
